seq_divider: RTL
================

# seq_divider

Sequential 8-bit restoring divider: the inverse of the shift-add multiplier. It takes a dividend and divisor, runs one shift/subtract iteration per quotient bit under an internal state machine, and returns the quotient and remainder with a completion handshake. It sits beside the multiplier in the arithmetic lab top level and is driven from the same switch/button front end.

## Interface
Parameters:
- none; operand width is fixed at 8 bits.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  level request; sampled only in IDLE.
- Dividend  in  8  dividend, captured on the accepting edge.
- Divisor  in  8  divisor, captured on the accepting edge.
- Quotient  out  8  registered result quotient.
- Remainder  out  8  registered result remainder.
- Busy  out  1  high in PREP/SHIFT/SUB/FIX.
- Done  out  1  high in DONE.
- DivZero  out  1  high in DONE when captured divisor was 0.

## Operation
- Working registers:
  - A: 9-bit partial remainder.
  - Q: 8-bit dividend/quotient shifter.
  - M: 8-bit divisor.
  - cnt: 3-bit iteration counter.
  - sgn_q, sgn_r: sign flags.
- Result registers (Quotient, Remainder, DivZero) update only on entry to DONE. They hold their last value through all other states.
- State machine:
  - IDLE: Start=1 → capture Dividend into Q, Divisor into M; clear A and cnt; go to PREP. Otherwise stay.
  - PREP: if M==0 → load Quotient=8'hFF, Remainder=Q (raw dividend), DivZero=1; go to DONE. Otherwise convert operands per Configuration; go to SHIFT.
  - SHIFT: {A,Q} <= {A,Q} << 1 (A[0] gets Q[7], Q[0] gets 0); go to SUB.
  - SUB: T = {1'b0,A} - {2'b0,M} (10-bit).
    - T[9]==0 → A <= T[8:0], Q[0] <= 1.
    - T[9]==1 → A unchanged (restore), Q[0] stays 0.
    - Then cnt <= cnt+1. If cnt==7 before the increment → FIX; else → SHIFT.
  - FIX: apply sign correction per Configuration; go to DONE.
  - DONE: on entry, load Quotient=Q, Remainder=A[7:0], DivZero=0. Stay while Start=1; go to IDLE on the first edge with Start=0.
- Start is ignored outside IDLE and DONE. Exactly one division is performed per Start assertion.
- A never exceeds 9 bits: A<M≤255 before each shift, so A≤509 after it.

## Timing
- Reset_n low, asynchronously:
  - State → IDLE.
  - A, Q, M, cnt, Quotient, Remainder → 0.
  - Busy, Done, DivZero → 0.
- Reset_n is released synchronously to Clk by the top level. Asserting it mid-operation aborts the division; there is no partial result.
- Edge 0 is the edge that samples Start=1 in IDLE. Busy goes high after edge 0.
- Normal latency:
  - Edge 1 → SHIFT.
  - Iteration k: SUB entered at edge 2k.
  - Edge 17 → FIX.
  - Edge 18 → DONE. Done and the results are valid after edge 18; Busy drops at the same time.
  - FIX costs one cycle even when unsigned, so latency is constant.
- Divide-by-zero latency: DONE after edge 1.
- DONE → IDLE one edge after Start is seen low. A new request needs Start low for at least one edge.
- Busy and Done are never both high. Both are low in IDLE.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined: operands are two's complement.
  - PREP: sgn_q = Dividend[7]^Divisor[7]; sgn_r = Dividend[7]. Q and M are replaced by their magnitudes (8-bit unsigned; -128 → 128).
  - FIX: negate Q if sgn_q; negate A[7:0] if sgn_r.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - -128 / -1 wraps to Quotient=8'h80, Remainder=0, with no flag.
- SEQ_DIVIDER_SIGNED_EN undefined: unsigned operation. PREP and FIX pass values through unchanged; sign flags are tied to 0.

## Test plan
- Unsigned, 200/7 → Quotient=8'h1C, Remainder=8'h04, DivZero=0. Done rises exactly 18 edges after edge 0; Busy is high for edges 0–17.
- 8'h55/0 → after edge 1: Done=1, DivZero=1, Quotient=8'hFF, Remainder=8'h55. A following 255/1 (unsigned) → 8'hFF, 0, DivZero=0.
- Signed build, -100/7 (8'h9C/8'h07) → Quotient=8'hF2 (-14), Remainder=8'hFE (-2). -128/-1 → 8'h80, 8'h00.
- Handshake:
  - Start held high 40 cycles → exactly one result; Done stays high.
  - Drop Start → IDLE one edge later, Done=0.
  - Start toggled during Busy → no effect on result or latency.
- Reset mid-operation: pull Reset_n low between edge 9 and edge 10 → all outputs 0 immediately, with no Clk edge. After release, 255/255 → Quotient=1, Remainder=0 at normal latency.
- Back-to-back: 13/4 then 4/13 with a one-cycle Start gap → (3,1) then (0,4). Result registers hold (3,1) throughout the second division until its DONE.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: 8-bit restoring divider, one shift cycle and one subtract cycle per quotient bit.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_divider (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic [7:0] Dividend,
    input  logic [7:0] Divisor,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SUB   = 3'd3;
    localparam logic [2:0] S_FIX   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0] state_q, state_d;
    logic [8:0] a_q, a_d;
    logic [7:0] q_q, q_d, m_q, m_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quot_q, quot_d, rem_q, rem_d;
    logic       dz_q, dz_d;
    logic       sgnq_q, sgnr_q;
    logic [9:0] diff;
    logic [7:0] q_fix, r_fix;

    function automatic logic [7:0] neg8(input logic [7:0] v);
        return ~v + 8'd1;
    endfunction

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sgnq_d, sgnr_d;

    function automatic logic [7:0] mag8(input logic [7:0] v);
        return v[7] ? neg8(v) : v;
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sgnq_q <= 1'b0;
            sgnr_q <= 1'b0;
        end else begin
            sgnq_q <= sgnq_d;
            sgnr_q <= sgnr_d;
        end
    end
`else
    assign sgnq_q = 1'b0;
    assign sgnr_q = 1'b0;
`endif

    // Bit 9 of the 10-bit difference is the borrow: set means restore.
    assign diff  = {1'b0, a_q} - {2'b0, m_q};
    assign q_fix = sgnq_q ? neg8(q_q) : q_q;
    assign r_fix = sgnr_q ? neg8(a_q[7:0]) : a_q[7:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
`endif
        case (state_q)
            S_IDLE: if (Start) begin
                q_d     = Dividend;
                m_d     = Divisor;
                a_d     = 9'd0;
                cnt_d   = 3'd0;
                state_d = S_PREP;
            end
            S_PREP: if (m_q == 8'd0) begin
                quot_d  = 8'hFF;
                rem_d   = q_q;
                dz_d    = 1'b1;
                state_d = S_DONE;
            end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                sgnq_d = q_q[7] ^ m_q[7];
                sgnr_d = q_q[7];
                q_d    = mag8(q_q);
                m_d    = mag8(m_q);
`endif
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d     = {a_q[7:0], q_q[7]};
                q_d     = {q_q[6:0], 1'b0};
                state_d = S_SUB;
            end
            S_SUB: begin
                if (!diff[9]) a_d = diff[8:0];
                q_d     = {q_q[7:1], ~diff[9]};
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? S_FIX : S_SHIFT;
            end
            // Correction and result load share one edge so DONE sees fixed values.
            S_FIX: begin
                q_d     = q_fix;
                a_d     = {1'b0, r_fix};
                quot_d  = q_fix;
                rem_d   = r_fix;
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: if (!Start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            a_q     <= 9'd0;
            q_q     <= 8'd0;
            m_q     <= 8'd0;
            cnt_q   <= 3'd0;
            quot_q  <= 8'd0;
            rem_q   <= 8'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivZero   = dz_q;
    assign Done      = (state_q == S_DONE);
    assign Busy      = (state_q == S_PREP) || (state_q == S_SHIFT) ||
                       (state_q == S_SUB)  || (state_q == S_FIX);
endmodule
